// File: rtl/paint_overlay_pipeline.sv
// Paint pipeline overlay stage: brush colour selector, crosshair cursor renderer
// and layer compositor feeding the VGA driver with one RGB888 pixel per request.
module paint_overlay_pipeline #(
    parameter  int WIDTH      = 640,
    parameter  int HEIGHT     = 480,
    parameter  int CURSOR_ARM = 2,
    localparam int XW         = $clog2(WIDTH),
    localparam int YW         = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          toggle,
    input  logic [XW-1:0] cursor_x,
    input  logic [YW-1:0] cursor_y,
    input  logic [XW-1:0] request_x,
    input  logic [YW-1:0] request_y,
    input  logic          cursor_visible,
    input  logic [2:0]    canvas1_color,
    input  logic [2:0]    canvas2_color,
    input  logic [2:0]    canvas3_color,
    input  logic [2:0]    canvas4_color,
    input  logic          canvas1_visible,
    input  logic          canvas2_visible,
    input  logic          canvas3_visible,
    input  logic          canvas4_visible,
    input  logic [7:0]    camera_r,
    input  logic [7:0]    camera_g,
    input  logic [7:0]    camera_b,
    output logic [2:0]    current_color,
    output logic [2:0]    cursor_color,
    output logic [7:0]    render_r,
    output logic [7:0]    render_g,
    output logic [7:0]    render_b
);

    localparam logic [2:0]  CODE_NONE  = 3'd0;
    localparam logic [2:0]  CODE_BLACK = 3'd1;
    // Arm length is assumed to fit the signed difference range of each axis.
    localparam logic [XW:0] ARM_X      = (XW+1)'(CURSOR_ARM);
    localparam logic [YW:0] ARM_Y      = (YW+1)'(CURSOR_ARM);

    function automatic logic [2:0] next_brush(input logic [2:0] code);
        return (code == 3'd7) ? CODE_BLACK : code + 3'd1;
    endfunction

    function automatic logic [23:0] palette(input logic [2:0] code);
        case (code)
            3'd1:    return 24'h000000;
            3'd2:    return 24'hFFFFFF;
            3'd3:    return 24'hFF0000;
            3'd4:    return 24'h00FF00;
            3'd5:    return 24'h0000FF;
            3'd6:    return 24'hFFFF00;
            3'd7:    return 24'hFF00FF;
            default: return 24'h000000;
        endcase
    endfunction

    logic        toggle_prev;
    logic [2:0]  brush_color;

    // toggle_prev resets high so a button held through reset release is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            toggle_prev <= 1'b1;
            brush_color <= CODE_BLACK;
        end else begin
            toggle_prev <= toggle;
            if (toggle && !toggle_prev)
                brush_color <= next_brush(brush_color);
        end
    end

    assign current_color = brush_color;

    // Stage p0: cursor hit test on the requested pixel
    logic signed [XW:0] dx_p0;
    logic signed [YW:0] dy_p0;
    logic        [XW:0] adx_p0;
    logic        [YW:0] ady_p0;
    logic               hit_p0;

    assign dx_p0  = $signed({1'b0, request_x}) - $signed({1'b0, cursor_x});
    assign dy_p0  = $signed({1'b0, request_y}) - $signed({1'b0, cursor_y});
    assign adx_p0 = dx_p0[XW] ? $unsigned(-dx_p0) : $unsigned(dx_p0);
    assign ady_p0 = dy_p0[YW] ? $unsigned(-dy_p0) : $unsigned(dy_p0);
    assign hit_p0 = ((dx_p0 == '0) && (ady_p0 <= ARM_Y)) ||
                    ((dy_p0 == '0) && (adx_p0 <= ARM_X));

    // Stage p1: registered cursor code, aligned with the canvas RAM read
    logic [2:0] cursor_code_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cursor_code_p1 <= CODE_NONE;
        else
            cursor_code_p1 <= hit_p0 ? brush_color : CODE_NONE;
    end

    assign cursor_color = cursor_code_p1;

    logic [2:0]  sel_code_p1;
    logic [23:0] rgb_p1;

    always_comb begin
        sel_code_p1 = CODE_NONE;
        if (cursor_visible && cursor_code_p1 != CODE_NONE)
            sel_code_p1 = cursor_code_p1;
        else if (canvas4_visible && canvas4_color != CODE_NONE)
            sel_code_p1 = canvas4_color;
        else if (canvas3_visible && canvas3_color != CODE_NONE)
            sel_code_p1 = canvas3_color;
        else if (canvas2_visible && canvas2_color != CODE_NONE)
            sel_code_p1 = canvas2_color;
        else if (canvas1_visible && canvas1_color != CODE_NONE)
            sel_code_p1 = canvas1_color;

        rgb_p1 = (sel_code_p1 == CODE_NONE) ? {camera_r, camera_g, camera_b}
                                            : palette(sel_code_p1);
    end

    assign render_r = rgb_p1[23:16];
    assign render_g = rgb_p1[15:8];
    assign render_b = rgb_p1[7:0];

endmodule

// File: tb/tb_paint_overlay_pipeline.sv
// Randomized scoreboard bench for paint_overlay_pipeline on an 8x8 screen.
module tb_paint_overlay_pipeline;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int ARM = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       toggle;
    logic [2:0] cursor_x, cursor_y, request_x, request_y;
    logic       cursor_visible;
    logic [2:0] canvas1_color, canvas2_color, canvas3_color, canvas4_color;
    logic       canvas1_visible, canvas2_visible, canvas3_visible, canvas4_visible;
    logic [7:0] camera_r, camera_g, camera_b;
    logic [2:0] current_color, cursor_color;
    logic [7:0] render_r, render_g, render_b;

    always #5 clk = ~clk;

    paint_overlay_pipeline #(.WIDTH(W), .HEIGHT(H), .CURSOR_ARM(ARM)) dut (
        .clk(clk), .reset(reset), .toggle(toggle),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .request_x(request_x), .request_y(request_y),
        .cursor_visible(cursor_visible),
        .canvas1_color(canvas1_color), .canvas2_color(canvas2_color),
        .canvas3_color(canvas3_color), .canvas4_color(canvas4_color),
        .canvas1_visible(canvas1_visible), .canvas2_visible(canvas2_visible),
        .canvas3_visible(canvas3_visible), .canvas4_visible(canvas4_visible),
        .camera_r(camera_r), .camera_g(camera_g), .camera_b(camera_b),
        .current_color(current_color), .cursor_color(cursor_color),
        .render_r(render_r), .render_g(render_g), .render_b(render_b)
    );

    typedef struct packed {
        logic            toggle;
        logic [2:0]      cx, cy, rx, ry;
        logic            cvis;
        logic [3:0][2:0] c;    // c[0] is canvas1
        logic [3:0]      v;
        logic [23:0]     cam;
    } stim_t;

    typedef struct {
        int          due;
        string       tag;
        logic [2:0]  cur;
        logic [2:0]  cc;
        logic [23:0] rgb;
    } exp_t;

    stim_t s;
    exp_t  q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    m_color, m_prev;

    function automatic logic [23:0] pal(input int code);
        logic [23:0] table_rgb [8] = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'hFF0000,
                                       24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'hFF00FF};
        return table_rgb[code];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic drive();
        toggle = s.toggle;
        cursor_x = s.cx; cursor_y = s.cy; request_x = s.rx; request_y = s.ry;
        cursor_visible = s.cvis;
        canvas1_color = s.c[0]; canvas2_color = s.c[1];
        canvas3_color = s.c[2]; canvas4_color = s.c[3];
        canvas1_visible = s.v[0]; canvas2_visible = s.v[1];
        canvas3_visible = s.v[2]; canvas4_visible = s.v[3];
        {camera_r, camera_g, camera_b} = s.cam;
    endtask

    // Reference: plus-shaped cursor of the colour held before the edge,
    // brush counts 1..7 cyclically on each new press, first visible layer wins.
    task automatic drive_issue(input string tag);
        exp_t e;
        int   dx, dy, sel;
        int   layers [5];
        drive();
        dx = int'(s.rx) - int'(s.cx);
        dy = int'(s.ry) - int'(s.cy);
        e.cc = ((dx == 0 && iabs(dy) <= ARM) || (dy == 0 && iabs(dx) <= ARM)) ? 3'(m_color) : 3'd0;
        if (s.toggle && m_prev == 0)
            m_color = (m_color % 7) + 1;
        m_prev = int'(s.toggle);
        e.cur = 3'(m_color);
        layers[0] = s.cvis ? int'(e.cc) : 0;
        for (int k = 0; k < 4; k++)
            layers[k+1] = s.v[3-k] ? int'(s.c[3-k]) : 0;
        sel = 0;
        for (int k = 0; k < 5; k++)
            if (sel == 0 && layers[k] != 0) sel = layers[k];
        e.rgb = (sel == 0) ? s.cam : pal(sel);
        e.tag = tag;
        e.due = cyc + 1;
        q.push_back(e);
    endtask

    task automatic apply(input string tag);
        @(negedge clk);
        drive_issue(tag);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        drive_issue(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_now(input string nm, input logic [31:0] act_sel, input logic [31:0] want);
        chk(nm, act_sel, want);
    endtask

    // Monitor: outputs are valid one edge after each issued request
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                if (e.due < cyc) begin
                    n_fail++;
                    $display("FAIL %s_late: due %0d seen %0d", e.tag, e.due, cyc);
                end else begin
                    chk({e.tag, "_cur"}, 32'(current_color), 32'(e.cur));
                    chk({e.tag, "_cc"}, 32'(cursor_color), 32'(e.cc));
                    chk({e.tag, "_rgb"}, 32'({render_r, render_g, render_b}), 32'(e.rgb));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int req [7][2] = '{'{4,2}, '{4,6}, '{2,4}, '{6,4}, '{4,4}, '{5,5}, '{4,7}};
        int req_cc [7] = '{3, 3, 3, 3, 3, 0, 0};
        logic [23:0] prio_rgb [4] = '{24'hFF0000, 24'h0000FF, 24'hFFFFFF, 24'h123456};

        reset = 1'b0;
        s = '0;
        s.toggle = 1'b1;
        s.cam = 24'h123456;
        drive();
        m_color = 1;
        m_prev = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_cur", 32'(current_color), 32'd1);
        chk("reset_cc", 32'(cursor_color), 32'd0);
        chk("reset_rgb", 32'({render_r, render_g, render_b}), 32'h123456);

        // Toggle held high across release must not advance the brush
        release_reset("release_held");
        apply("held");
        s.toggle = 1'b0;
        s.cvis = 1'b1; s.cx = 3'd4; s.cy = 3'd4; s.rx = 3'd0; s.ry = 3'd0;
        apply("idle");

        for (int i = 0; i < 7; i++) begin
            s.toggle = 1'b1; apply("pulse_hi");
            s.toggle = 1'b0; apply("pulse_lo");
        end
        @(posedge clk); #1;
        chk("seven_pulses", 32'(current_color), 32'd1);

        s.toggle = 1'b1;
        repeat (5) apply("hold");
        s.toggle = 1'b0;
        apply("hold_rel");
        @(posedge clk); #1;
        chk("hold_once", 32'(current_color), 32'd2);

        s.toggle = 1'b1; apply("to3_hi");
        s.toggle = 1'b0; apply("to3_lo");

        for (int i = 0; i < 7; i++) begin
            s.rx = 3'(req[i][0]); s.ry = 3'(req[i][1]);
            apply("cross");
            @(posedge clk); #1;
            chk("cross_direct", 32'(cursor_color), 32'(req_cc[i]));
        end

        s.cx = 3'd0; s.cy = 3'd0; s.rx = 3'd7; s.ry = 3'd0;
        apply("nowrap");
        @(posedge clk); #1;
        chk("nowrap_direct", 32'(cursor_color), 32'd0);
        s.rx = 3'd2;
        apply("edge_arm");
        @(posedge clk); #1;
        chk("edge_arm_direct", 32'(cursor_color), 32'd3);

        s.cx = 3'd4; s.cy = 3'd4; s.rx = 3'd4; s.ry = 3'd4;
        s.v = 4'b1111;
        s.c[0] = 3'd2; s.c[1] = 3'd5; s.c[2] = 3'd0; s.c[3] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) s.cvis = 1'b0;
            if (i == 2) s.v[1] = 1'b0;
            if (i == 3) s.c[0] = 3'd0;
            apply("prio");
            @(posedge clk); #1;
            chk("prio_direct", 32'({render_r, render_g, render_b}), 32'(prio_rgb[i]));
        end

        for (int i = 0; i < 400; i++) begin
            s.toggle = ($urandom_range(0, 9) < 3);
            s.cx = 3'($urandom_range(0, 7));
            s.cy = 3'($urandom_range(0, 7));
            s.rx = $urandom_range(0, 1) ? s.cx : 3'($urandom_range(0, 7));
            s.ry = $urandom_range(0, 1) ? s.cy : 3'($urandom_range(0, 7));
            s.cvis = ($urandom_range(0, 3) != 0);
            s.c = 12'($urandom);
            s.v = 4'($urandom);
            s.cam = 24'($urandom);
            apply("rand");
        end

        s.toggle = 1'b0;
        apply("pre6");
        for (int i = 0; i < 8 && m_color != 6; i++) begin
            s.toggle = 1'b1; apply("to6_hi");
            s.toggle = 1'b0; apply("to6_lo");
        end
        s.cx = 3'd3; s.cy = 3'd3; s.rx = 3'd3; s.ry = 3'd3;
        s.cvis = 1'b1; s.v = 4'b0000; s.cam = 24'hA5C3E1;
        apply("mid_hit");
        apply("mid_hit");
        drain();
        chk("pre_reset_cur", 32'(current_color), 32'd6);
        chk("pre_reset_cc", 32'(cursor_color), 32'd6);

        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_cur", 32'(current_color), 32'd1);
        chk("async_cc", 32'(cursor_color), 32'd0);
        chk("async_rgb", 32'({render_r, render_g, render_b}), 32'hA5C3E1);
        m_color = 1;
        m_prev = 1;

        release_reset("rerelease");
        s.toggle = 1'b1; apply("post_hi");
        s.toggle = 1'b0; apply("post_lo");
        apply("post_idle");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/paint_overlay_pipeline.md
Name: paint_overlay_pipeline

Overview:
- Pixel-overlay stage of the paint pipeline, between the mouse/tool logic and the VGA driver.
- Holds the current brush colour; the user cycles it with a toggle input (mouse right button).
- Renders a crosshair cursor at the mouse position for each VGA-requested pixel.
- Composites cursor, four canvas layers and the camera image into one RGB888 pixel.

Parameters:
- WIDTH, 640, screen width in pixels; XW = $clog2(WIDTH).
- HEIGHT, 480, screen height in pixels; YW = $clog2(HEIGHT).
- CURSOR_ARM, 2, crosshair arm length in pixels, excluding the centre pixel.

Ports:
- clk  in  1  system clock (50 MHz); all state on its rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- toggle  in  1  synchronized level; each rising edge advances the brush colour.
- cursor_x  in  XW  cursor column.
- cursor_y  in  YW  cursor row.
- request_x  in  XW  VGA-requested column.
- request_y  in  YW  VGA-requested row.
- cursor_visible  in  1  enables the cursor overlay.
- canvasN_color  in  3  canvas layer N pixel code, N = 1..4.
- canvasN_visible  in  1  layer N enable, N = 1..4.
- camera_r, camera_g, camera_b  in  8 each  camera background pixel.
- current_color  out  3  current brush colour code.
- cursor_color  out  3  registered cursor pixel code for the requested pixel.
- render_r, render_g, render_b  out  8 each  final composited pixel.

Behaviour:
- Colour codes (3 bits):
  - 0 NONE (transparent)
  - 1 black 000000
  - 2 white FFFFFF
  - 3 red FF0000
  - 4 green 00FF00
  - 5 blue 0000FF
  - 6 yellow FFFF00
  - 7 magenta FF00FF
- Colour selector:
  - Register toggle_prev; reset value 1, so a toggle held high through reset release does not advance.
  - Rising edge = toggle & ~toggle_prev, detected in one cycle.
  - On a rising edge, current_color increments; 7 wraps to 1. NONE is never selected.
  - current_color reset value 1 (black). Output is registered; the change is visible the cycle after the edge.
  - Holding toggle high advances only once.
- Cursor renderer:
  - dx = request_x − cursor_x and dy = request_y − cursor_y, computed signed at XW+1 / YW+1 bits. No wrap-around across screen edges.
  - A pixel is on the cursor if (dx==0 and |dy|<=CURSOR_ARM) or (dy==0 and |dx|<=CURSOR_ARM).
  - On the cursor, cursor_color = current_color; otherwise cursor_color = NONE.
  - cursor_color is registered with 1-cycle latency, matching the canvas RAM read latency. Reset value NONE.
  - Arms extending off-screen are simply clipped.
- Compositor:
  - Purely combinational from cursor_color, the canvas inputs and the camera inputs.
  - First match wins:
    1. cursor_visible and cursor_color≠NONE
    2. canvas4
    3. canvas3
    4. canvas2
    5. canvas1 (each canvas only if visible and its code ≠ NONE)
    6. camera RGB passthrough
  - Canvas and cursor codes map through the palette above.
  - During reset the outputs equal camera RGB, because cursor_color is NONE.
- Reset asserted mid-operation: current_color returns to 1 and cursor_color to NONE immediately (asynchronous).

Test Plan:
- Reset with WIDTH=HEIGHT=8, then release: current_color=1, cursor_color=0; render = camera input (e.g. 12/34/56).
- Pulse toggle 0→1→0 seven times: current_color steps 2,3,4,5,6,7,1. Hold toggle high 5 cycles: exactly one increment.
- cursor=(4,4), current_color=3, cursor_visible=1:
  - request (4,2), (4,6), (2,4), (6,4), (4,4) → cursor_color=3 one cycle later.
  - request (5,5) and (4,7) → cursor_color=0.
- cursor=(0,0), request=(7,0) → cursor_color=0 (no wrap). Request (2,0) → 3.
- Priority, all layers visible:
  - canvas1=2, canvas2=5, cursor hit with colour 3 → FF0000.
  - cursor_visible=0 → 0000FF.
  - canvas2_visible=0 → FFFFFF.
  - canvas1=0 → camera RGB.
- Assert reset mid-frame while current_color=6: current_color=1 and cursor_color=0 without waiting for a clock edge.
